// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial WIDTH-bit adder built around one full_adder2.
// Operands are latched on an accepted start and consumed LSB first, one bit
// per clock. The sum, carry-out and overflow are registered on the final RUN
// edge, and done pulses for one cycle.
// Optional feature: define SERIAL_ADDER_OVF_EN to build the signed-overflow
// flag. Without it, ovf is tied to 0 and the port list is unchanged.

module full_adder2 (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic s,
  output logic cout
);
  // One-bit full adder.
  assign s    = x ^ y ^ cin;
  assign cout = (x & y) | (cin & (x ^ y));
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] a_sr_reg;
  logic [WIDTH-1:0] b_sr_reg;
  logic [WIDTH-1:0] s_sr_reg;
  logic             carry_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             busy_reg;
  logic             done_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             cout_reg;
  logic             fa_s;
  logic             fa_cout;

  // The single shared adder cell, fed from the operand LSBs and the carry flop.
  full_adder2 u_fa (
    .x    (a_sr_reg[0]),
    .y    (b_sr_reg[0]),
    .cin  (carry_reg),
    .s    (fa_s),
    .cout (fa_cout)
  );

  // Sequencer: load on start, shift one bit per RUN edge, register results.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_IDLE;
      a_sr_reg  <= '0;
      b_sr_reg  <= '0;
      s_sr_reg  <= '0;
      carry_reg <= 1'b0;
      cnt_reg   <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      sum_reg   <= '0;
      cout_reg  <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          done_reg <= 1'b0;
          if (start) begin
            a_sr_reg  <= a;
            b_sr_reg  <= b;
            carry_reg <= cin;
            cnt_reg   <= '0;
            busy_reg  <= 1'b1;
            state_reg <= S_RUN;
          end
        end
        S_RUN: begin
          a_sr_reg  <= a_sr_reg >> 1;
          b_sr_reg  <= b_sr_reg >> 1;
          s_sr_reg  <= {fa_s, s_sr_reg[WIDTH-1:1]};
          carry_reg <= fa_cout;
          if (cnt_reg == LAST_BIT) begin
            // Counter holds on the last bit so it never wraps mid-operation.
            sum_reg   <= {fa_s, s_sr_reg[WIDTH-1:1]};
            cout_reg  <= fa_cout;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
            state_reg <= S_DONE;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        S_DONE: begin
          done_reg  <= 1'b0;
          state_reg <= S_IDLE;
        end
        default: begin
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

`ifdef SERIAL_ADDER_OVF_EN
  logic ovf_reg;

  // During the last RUN cycle the carry flop holds the carry into the MSB,
  // so XOR with the MSB carry-out gives two's-complement overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_reg <= 1'b0;
    end else if (state_reg == S_RUN && cnt_reg == LAST_BIT) begin
      ovf_reg <= carry_reg ^ fa_cout;
    end
  end

  assign ovf = ovf_reg;
`else
  assign ovf = 1'b0;
`endif

  assign busy = busy_reg;
  assign done = done_reg;
  assign sum  = sum_reg;
  assign cout = cout_reg;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed and randomized bench for serial_adder_ctrl at WIDTH=8 and WIDTH=16.
// Expected results are queued when an operation is driven and popped on done.

module tb_serial_adder_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic        start8, start16;
  logic [31:0] a_in, b_in;
  logic        cin_in;
  logic        busy8, done8, cout8, ovf8;
  logic        busy16, done16, cout16, ovf16;
  logic [7:0]  sum8;
  logic [15:0] sum16;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  exp_t sbq[$];

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .a(a_in[7:0]), .b(b_in[7:0]),
    .cin(cin_in), .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
  );

  serial_adder_ctrl #(.WIDTH(16)) dut16 (
    .clk(clk), .reset(reset), .start(start16), .a(a_in[15:0]), .b(b_in[15:0]),
    .cin(cin_in), .busy(busy16), .done(done16), .sum(sum16), .cout(cout16), .ovf(ovf16)
  );

  function automatic logic get_busy(int w);
    return (w == 8) ? busy8 : busy16;
  endfunction
  function automatic logic get_done(int w);
    return (w == 8) ? done8 : done16;
  endfunction
  function automatic logic [31:0] get_sum(int w);
    return (w == 8) ? {24'd0, sum8} : {16'd0, sum16};
  endfunction
  function automatic logic get_cout(int w);
    return (w == 8) ? cout8 : cout16;
  endfunction
  function automatic logic get_ovf(int w);
    return (w == 8) ? ovf8 : ovf16;
  endfunction

  task automatic set_start(int w, logic v);
    start8  = (w == 8)  && v;
    start16 = (w == 16) && v;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Drive one operation and follow it to done. inj_run > 0 pulses a stray
  // start in that RUN cycle; inj_done pulses one in the DONE cycle.
  task automatic op(int w, logic [31:0] av, logic [31:0] bv, logic cv,
                    int inj_run, bit inj_done);
    logic [31:0] mask, prev, am, bm;
    logic [32:0] full;
    exp_t e, got;
    int bc;
    bit seen;
    mask = (32'h1 << w) - 32'h1;
    am   = av & mask;
    bm   = bv & mask;
    full = {1'b0, am} + {1'b0, bm} + {32'd0, cv};
    e.sum  = full[31:0] & mask;
    e.cout = full[w];
`ifdef SERIAL_ADDER_OVF_EN
    e.ovf  = (am[w-1] == bm[w-1]) && (e.sum[w-1] != am[w-1]);
`else
    e.ovf  = 1'b0;
`endif
    sbq.push_back(e);
    prev = get_sum(w);

    @(negedge clk);
    a_in = av; b_in = bv; cin_in = cv;
    set_start(w, 1'b1);
    @(negedge clk);
    bc = 0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      set_start(w, 1'b0);
      a_in = $urandom; b_in = $urandom; cin_in = 1'($urandom);
      if (get_done(w)) begin
        seen = 1'b1;
      end else begin
        if (get_busy(w)) bc++;
        chk("sum_stable_run", get_sum(w), prev);
        if (bc == inj_run) begin
          a_in = 32'h11; b_in = 32'h22; cin_in = 1'b0;
          set_start(w, 1'b1);
        end
        @(negedge clk);
      end
    end
    chk("done_seen", {31'd0, seen}, 32'd1);
    chk("busy_cycles", bc, w);
    chk("busy_with_done", {31'd0, get_busy(w)}, 32'd0);

    got.sum  = get_sum(w);
    got.cout = get_cout(w);
    got.ovf  = get_ovf(w);
    e = sbq.pop_front();
    chk("sum", got.sum, e.sum);
    chk("cout", {31'd0, got.cout}, {31'd0, e.cout});
    chk("ovf", {31'd0, got.ovf}, {31'd0, e.ovf});
    $display("op w=%0d a=%0h b=%0h cin=%0d -> sum=%0h cout=%0d ovf=%0d (exp %0h/%0d/%0d)",
             w, am, bm, cv, got.sum, got.cout, got.ovf, e.sum, e.cout, e.ovf);

    if (inj_done) begin
      a_in = 32'h11; b_in = 32'h22;
      set_start(w, 1'b1);
    end
    @(negedge clk);
    set_start(w, 1'b0);
    chk("done_one_cycle", {31'd0, get_done(w)}, 32'd0);
    chk("idle_after_done", {31'd0, get_busy(w)}, 32'd0);
    @(negedge clk);
    chk("start_in_done_dropped", {31'd0, get_busy(w)}, 32'd0);
  endtask

  initial begin
    int done_cnt;
    reset = 1'b1; start8 = 1'b0; start16 = 1'b0;
    a_in = '0; b_in = '0; cin_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy8}, 32'd0);
    chk("rst_done", {31'd0, done8}, 32'd0);
    chk("rst_sum", {24'd0, sum8}, 32'd0);
    chk("rst_cout", {31'd0, cout8}, 32'd0);
    chk("rst_ovf", {31'd0, ovf8}, 32'd0);
    chk("rst_sum16", {16'd0, sum16}, 32'd0);
    reset = 1'b0;

    op(8, 32'h0F, 32'h01, 1'b0, 0, 1'b0);
    op(8, 32'hFF, 32'h00, 1'b1, 0, 1'b0);
    op(8, 32'hFF, 32'hFF, 1'b1, 0, 1'b0);
    op(8, 32'h7F, 32'h01, 1'b0, 0, 1'b0);
    op(8, 32'h80, 32'h80, 1'b0, 0, 1'b0);
    // Stray starts in RUN cycle 3 and in DONE must be ignored.
    op(8, 32'h01, 32'h02, 1'b0, 3, 1'b1);
    op(8, 32'h11, 32'h22, 1'b0, 0, 1'b0);
    op(16, 32'h7FFF, 32'h0001, 1'b0, 0, 1'b0);

    // Abort in the fourth RUN cycle; start while in reset is ignored.
    @(negedge clk);
    a_in = 32'h01; b_in = 32'h02; cin_in = 1'b0;
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    start8 = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    start8 = 1'b0;
    chk("abort_busy", {31'd0, busy8}, 32'd0);
    chk("abort_done", {31'd0, done8}, 32'd0);
    chk("abort_sum", {24'd0, sum8}, 32'd0);
    chk("abort_cout", {31'd0, cout8}, 32'd0);
    chk("abort_ovf", {31'd0, ovf8}, 32'd0);
    done_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done8 || busy8) done_cnt++;
    end
    chk("no_done_after_abort", done_cnt, 0);
    op(8, 32'h05, 32'h03, 1'b0, 0, 1'b0);

    for (int i = 0; i < 1000; i++)
      op(8, $urandom, $urandom, 1'($urandom_range(0, 1)), 0, 1'b0);
    for (int i = 0; i < 1000; i++)
      op(16, $urandom, $urandom, 1'($urandom_range(0, 1)), 0, 1'b0);

    chk("scoreboard_empty", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
